pe_result_packer: RTL

- Downstream stage of the processing element.
- Accepts the PE's 40-bit result stream over valid/ready.
- Saturates or truncates each result to 16 bits and packs four results into a 64-bit word.
- Writes packed words to the output activation SRAM at consecutive word addresses from a programmed base; signals done once the programmed result count is written.

---
 rtl/pe_result_packer_pkg.sv | 32 +++
 rtl/sat_narrow_40to16.sv | 32 +++
 rtl/pe_result_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pe_result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_packer_pkg
// Brief    : Shared constants, state encodings and helpers for the PE packer.
// Revision : 1.0 - initial release
// ============================================================================
package pe_result_packer_pkg;

    localparam int LANE_W         = 16;
    localparam int LANES_PER_WORD = 4;
    localparam int WORD_W         = LANE_W * LANES_PER_WORD;

    localparam logic [1:0] PKR_IDLE    = 2'd0;
    localparam logic [1:0] PKR_COLLECT = 2'd1;
    localparam logic [1:0] PKR_DRAIN   = 2'd2;
    localparam logic [1:0] PKR_DONE    = 2'd3;

    localparam logic [LANE_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [LANE_W-1:0] SAT_NEG = 16'h8000;

    // Byte enables covering lanes 0..last_lane.
    function automatic logic [7:0] lane_strb(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    lane_strb = 8'h03;
            2'd1:    lane_strb = 8'h0F;
            2'd2:    lane_strb = 8'h3F;
            default: lane_strb = 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_narrow_40to16.sv
`default_nettype none
// ============================================================================
// Module   : sat_narrow_40to16
// Brief    : Combinational 40->16 signed clamp (or plain truncation) with flag.
// Revision : 1.0 - initial release
// ============================================================================
module sat_narrow_40to16
    import pe_result_packer_pkg::*;
#(
    parameter bit SAT_EN = 1'b1
) (
    input  logic [39:0]       i_data,
    output logic [LANE_W-1:0] o_data,
    output logic              o_sat
);

    if (SAT_EN) begin : g_sat
        logic w_hi;
        logic w_lo;
        assign w_hi   = $signed(i_data) > 40'sd32767;
        assign w_lo   = $signed(i_data) < -40'sd32768;
        assign o_data = w_hi ? SAT_POS : (w_lo ? SAT_NEG : i_data[LANE_W-1:0]);
        assign o_sat  = w_hi | w_lo;
    end else begin : g_trunc
        logic w_unused_hi;
        assign w_unused_hi = ^i_data[39:LANE_W];
        assign o_data      = i_data[LANE_W-1:0];
        assign o_sat       = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_packer
// Brief    : Narrows 40-bit PE results to 16 bits, packs 4 per 64-bit word and
//            writes them to the output activation SRAM from a base address.
// Revision : 1.0 - initial release
// ============================================================================
module pe_result_packer
    import pe_result_packer_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_results,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sat_count,
    input  logic [39:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic [7:0]        mem_wr_strb,
    input  logic              mem_wr_ready
);

    logic [1:0]        r_state,     w_state_nxt;
    logic [1:0]        r_lane,      w_lane_nxt;
    logic [15:0]       r_remaining, w_rem_nxt;
    logic [WORD_W-1:0] r_pack,      w_pack_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic [15:0]       r_sat_count, w_sat_nxt;
    logic              r_in_ready,  w_in_ready_nxt;
    logic              r_wr_en,     w_wr_en_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [WORD_W-1:0] r_data,      w_data_nxt;
    logic [7:0]        r_strb,      w_strb_nxt;

    logic [LANE_W-1:0] w_lane;
    logic              w_sat;
    logic              w_accept;
    logic              w_wr_done;
    logic [WORD_W-1:0] w_lane_word;

    sat_narrow_40to16 #(
        .SAT_EN (SAT_EN)
    ) u_narrow (
        .i_data (in_data),
        .o_data (w_lane),
        .o_sat  (w_sat)
    );

    // in_ready is only ever high in COLLECT with no write pending.
    assign w_accept    = in_valid && r_in_ready;
    assign w_wr_done   = r_wr_en && mem_wr_ready;
    assign w_lane_word = r_pack | ({{(WORD_W-LANE_W){1'b0}}, w_lane} << {r_lane, 4'b0000});

    always_comb begin
        w_state_nxt    = r_state;
        w_lane_nxt     = r_lane;
        w_rem_nxt      = r_remaining;
        w_pack_nxt     = r_pack;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_sat_nxt      = r_sat_count;
        w_in_ready_nxt = r_in_ready;
        w_wr_en_nxt    = r_wr_en;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_strb_nxt     = r_strb;

        case (r_state)
            PKR_IDLE: begin
                if (start && !abort) begin
                    if (num_results != 16'd0) begin
                        w_state_nxt    = PKR_COLLECT;
                        w_addr_nxt     = base_addr;
                        w_rem_nxt      = num_results;
                        w_sat_nxt      = 16'd0;
                        w_busy_nxt     = 1'b1;
                        w_in_ready_nxt = 1'b1;
                        w_lane_nxt     = 2'd0;
                        w_pack_nxt     = '0;
                    end else begin
                        w_state_nxt = PKR_DONE;
                    end
                end
            end
            PKR_COLLECT: begin
                if (w_wr_done) begin
                    w_wr_en_nxt    = 1'b0;
                    w_addr_nxt     = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_in_ready_nxt = 1'b1;
                end
                if (w_accept) begin
                    w_pack_nxt = w_lane_word;
                    w_lane_nxt = r_lane + 2'd1;
                    w_rem_nxt  = r_remaining - 16'd1;
                    if (w_sat && (r_sat_count != 16'hFFFF)) begin
                        w_sat_nxt = r_sat_count + 16'd1;
                    end
                    // Emit on a full word or on the job's last result.
                    if ((r_lane == 2'd3) || (r_remaining == 16'd1)) begin
                        w_wr_en_nxt    = 1'b1;
                        w_data_nxt     = w_lane_word;
                        w_strb_nxt     = lane_strb(r_lane);
                        w_pack_nxt     = '0;
                        w_lane_nxt     = 2'd0;
                        w_in_ready_nxt = 1'b0;
                        if (r_remaining == 16'd1) begin
                            w_state_nxt = PKR_DRAIN;
                        end
                    end
                end
            end
            PKR_DRAIN: begin
                if (w_wr_done) begin
                    w_wr_en_nxt = 1'b0;
                    w_addr_nxt  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = PKR_DONE;
                end
            end
            default: begin
                w_state_nxt = PKR_IDLE;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Abort discards any pending write and the partially packed word.
        if (abort && (r_state != PKR_IDLE)) begin
            w_state_nxt    = PKR_IDLE;
            w_wr_en_nxt    = 1'b0;
            w_in_ready_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b0;
            w_lane_nxt     = 2'd0;
            w_pack_nxt     = '0;
            w_rem_nxt      = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PKR_IDLE;
            r_lane      <= 2'd0;
            r_remaining <= 16'd0;
            r_pack      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sat_count <= 16'd0;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_strb      <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_remaining <= w_rem_nxt;
            r_pack      <= w_pack_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_sat_count <= w_sat_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_strb      <= w_strb_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sat_count   = r_sat_count;
    assign in_ready    = r_in_ready;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_addr;
    assign mem_wr_data = r_data;
    assign mem_wr_strb = r_strb;

endmodule
`default_nettype wire
